// File: rtl/sp_ram_arb_pkg.sv
// Shared types and sizing helpers for the single-port RAM arbiter.
// Imported by the picker and the arbiter top.
package sp_ram_arb_pkg;

  typedef enum logic {
    ARB_UNLOCKED = 1'b0,
    ARB_LOCKED   = 1'b1
  } arb_state_e;

  function automatic int cnt_w(int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sp_ram_rr_pick.sv
// Rotate-priority picker: first masked request at or after i_ptr.
// Purely combinational; one-hot grant plus binary index.
module sp_ram_rr_pick
  import sp_ram_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic [N-1:0]  i_mask,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic [N-1:0] w_req;

  assign w_req = i_req & i_mask;

  // scan from i_ptr upward, wrapping, and keep the first hit
  always_comb begin
    int j;
    j       = 0;
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(i_ptr) + k) % N;
      if (!o_valid && w_req[j]) begin
        o_valid  = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between requesters,
// with bus lock for atomic sequences and a watchdog on idle locks.
module sp_ram_arbiter
  import sp_ram_arb_pkg::*;
#(
  parameter int NUM_PORTS    = 2,
  parameter int ADDR_WIDTH   = 17,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            req_i,
  input  logic [NUM_PORTS-1:0]            lock_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_PORTS*32-1:0]         wdata_i,
  input  logic [NUM_PORTS-1:0]            we_i,
  input  logic [NUM_PORTS*4-1:0]          be_i,
  output logic [NUM_PORTS-1:0]            gnt_o,
  output logic [NUM_PORTS-1:0]            rvalid_o,
  output logic [31:0]                     rdata_o,
  output logic                            lock_timeout_o,
  output logic                            ram_en_o,
  output logic [ADDR_WIDTH-1:0]           ram_addr_o,
  output logic [31:0]                     ram_wdata_o,
  output logic                            ram_we_o,
  output logic [3:0]                      ram_be_o,
  input  logic [31:0]                     ram_rdata_i
);

  localparam int IW = idx_w(NUM_PORTS);
  localparam int CW = cnt_w(LOCK_TIMEOUT);

  arb_state_e           r_state;
  logic [IW-1:0]        r_owner;
  logic [IW-1:0]        r_rr_ptr;
  logic [CW-1:0]        r_lock_cnt;
  logic [NUM_PORTS-1:0] r_rvalid;

  logic [NUM_PORTS-1:0] w_mask;
  logic [NUM_PORTS-1:0] w_gnt;
  logic [IW-1:0]        w_idx;
  logic                 w_any;
  logic [IW-1:0]        w_sel;
  logic [IW-1:0]        w_next_ptr;
  logic                 w_owner_idle;
  logic                 w_timeout;

  // while locked only the owner may win
  always_comb begin
    w_mask = '1;
    if (r_state == ARB_LOCKED) begin
      w_mask          = '0;
      w_mask[r_owner] = 1'b1;
    end
  end

  sp_ram_rr_pick #(
    .N  (NUM_PORTS),
    .IW (IW)
  ) u_pick (
    .i_req   (req_i),
    .i_ptr   (r_rr_ptr),
    .i_mask  (w_mask),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_valid (w_any)
  );

  assign w_owner_idle = (r_state == ARB_LOCKED) && !req_i[r_owner];
  assign w_timeout    = w_owner_idle &&
                        (r_lock_cnt == CW'(LOCK_TIMEOUT - 1));
  assign w_next_ptr   = IW'((int'(w_idx) + 1) % NUM_PORTS);
  assign w_sel        = w_any ? w_idx : '0;

  assign gnt_o          = w_gnt;
  assign rvalid_o       = r_rvalid;
  assign rdata_o        = ram_rdata_i;
  assign lock_timeout_o = w_timeout;
  assign ram_en_o       = w_any;
  assign ram_addr_o     = addr_i[int'(w_sel)*ADDR_WIDTH +: ADDR_WIDTH];
  assign ram_wdata_o    = wdata_i[int'(w_sel)*32 +: 32];
  assign ram_we_o       = we_i[w_sel];
  assign ram_be_o       = be_i[int'(w_sel)*4 +: 4];

  // lock FSM, rotation pointer, watchdog and response strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARB_UNLOCKED;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_lock_cnt <= '0;
      r_rvalid   <= '0;
    end else begin
      r_rvalid <= w_gnt;
      if (w_any) r_rr_ptr <= w_next_ptr;
      unique case (r_state)
        ARB_UNLOCKED: begin
          if (w_any && lock_i[w_idx]) begin
            r_state    <= ARB_LOCKED;
            r_owner    <= w_idx;
            r_lock_cnt <= '0;
          end
        end
        ARB_LOCKED: begin
          if (w_timeout) begin
            r_state    <= ARB_UNLOCKED;
            r_lock_cnt <= '0;
          end else if (w_any) begin
            if (!lock_i[w_idx]) r_state <= ARB_UNLOCKED;
            r_lock_cnt <= '0;
          end else begin
            r_lock_cnt <= r_lock_cnt + CW'(1);
          end
        end
        default: r_state <= ARB_UNLOCKED;
      endcase
    end
  end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Bench for sp_ram_arbiter: directed scenarios plus random traffic,
// checked every cycle against a behavioural arbitration/memory model.
module tb_sp_ram_arbiter;

  localparam int NP = 2;
  localparam int AW = 17;
  localparam int TO = 16;

  logic              clk;
  logic              rst_n;
  logic [NP-1:0]     req, lock, we;
  logic [NP*AW-1:0]  addr;
  logic [NP*32-1:0]  wdata;
  logic [NP*4-1:0]   be;
  logic [NP-1:0]     gnt_o, rvalid_o;
  logic [31:0]       rdata_o;
  logic              lock_timeout_o;
  logic              ram_en_o, ram_we_o;
  logic [AW-1:0]     ram_addr_o;
  logic [31:0]       ram_wdata_o, ram_rdata;
  logic [3:0]        ram_be_o;

  int n_pass = 0;
  int n_tot  = 0;

  sp_ram_arbiter #(
    .NUM_PORTS    (NP),
    .ADDR_WIDTH   (AW),
    .LOCK_TIMEOUT (TO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_i          (req),
    .lock_i         (lock),
    .addr_i         (addr),
    .wdata_i        (wdata),
    .we_i           (we),
    .be_i           (be),
    .gnt_o          (gnt_o),
    .rvalid_o       (rvalid_o),
    .rdata_o        (rdata_o),
    .lock_timeout_o (lock_timeout_o),
    .ram_en_o       (ram_en_o),
    .ram_addr_o     (ram_addr_o),
    .ram_wdata_o    (ram_wdata_o),
    .ram_we_o       (ram_we_o),
    .ram_be_o       (ram_be_o),
    .ram_rdata_i    (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endtask

  // RAM wrapper: one-cycle read latency, byte-enabled writes
  logic [31:0] ram_mem [int];
  always @(posedge clk) begin
    int a;
    logic [31:0] w;
    if (ram_en_o) begin
      a = int'(ram_addr_o);
      w = ram_mem.exists(a) ? ram_mem[a] : 32'h0;
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_be_o[b]) w[b*8 +: 8] = ram_wdata_o[b*8 +: 8];
        ram_mem[a] = w;
      end else begin
        ram_rdata <= w;
      end
    end
  end

  // behavioural model
  bit          m_locked;
  int          m_owner, m_rr, m_cnt;
  logic [NP-1:0] m_rv;
  bit          m_rd_read;
  logic [31:0] m_rdata;
  logic [31:0] shadow [int];

  always @(negedge clk) begin
    int ew, sel, a;
    logic [NP-1:0] eg;
    bit eto;
    if (!rst_n) begin
      m_locked = 0; m_owner = 0; m_rr = 0; m_cnt = 0;
      m_rv = '0; m_rd_read = 0;
    end
    ew = -1;
    if (m_locked) begin
      if (req[m_owner]) ew = m_owner;
    end else begin
      for (int k = 0; k < NP; k++)
        if (ew < 0 && req[(m_rr + k) % NP]) ew = (m_rr + k) % NP;
    end
    eg = '0;
    if (ew >= 0) eg[ew] = 1'b1;
    eto = m_locked && !req[m_owner] && (m_cnt == TO - 1);
    sel = (ew >= 0) ? ew : 0;
    chk("gnt", gnt_o, eg);
    chk("ram_en", ram_en_o, ew >= 0);
    chk("lock_timeout", lock_timeout_o, eto);
    chk("rvalid", rvalid_o, m_rv);
    if (m_rv != 0 && m_rd_read) chk("rdata", rdata_o, m_rdata);
    chk("ram_addr", ram_addr_o, addr[sel*AW +: AW]);
    chk("ram_wdata", ram_wdata_o, wdata[sel*32 +: 32]);
    chk("ram_we", ram_we_o, we[sel]);
    chk("ram_be", ram_be_o, be[sel*4 +: 4]);
    if (rst_n) begin
      m_rv = eg;
      m_rd_read = 0;
      if (ew >= 0) begin
        a = int'(addr[ew*AW +: AW]);
        if (!shadow.exists(a)) shadow[a] = 32'h0;
        if (we[ew]) begin
          for (int b = 0; b < 4; b++)
            if (be[ew*4 + b])
              shadow[a][b*8 +: 8] = wdata[ew*32 + b*8 +: 8];
        end else begin
          m_rd_read = 1;
          m_rdata = shadow[a];
        end
        m_rr = (ew + 1) % NP;
      end
      if (!m_locked) begin
        if (ew >= 0 && lock[ew]) begin
          m_locked = 1; m_owner = ew; m_cnt = 0;
        end
      end else if (ew >= 0) begin
        if (!lock[ew]) m_locked = 0;
        m_cnt = 0;
      end else if (m_cnt == TO - 1) begin
        m_locked = 0; m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
  end

  task automatic set_port(int p, bit r, bit l, int a,
                          logic [31:0] d, bit w, logic [3:0] b);
    req[p] = r;
    lock[p] = l;
    addr[p*AW +: AW] = AW'(a);
    wdata[p*32 +: 32] = d;
    we[p] = w;
    be[p*4 +: 4] = b;
  endtask

  task automatic clear_all();
    req = '0; lock = '0; addr = '0; wdata = '0; we = '0; be = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_all();
    tick();
    rst_n = 1'b1;
  endtask

  int quiet [NP];

  initial begin
    rst_n = 1'b1;
    clear_all();
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_gnt", gnt_o, 2'b00);
    chk("rst_rvalid", rvalid_o, 2'b00);
    chk("rst_timeout", lock_timeout_o, 1'b0);
    chk("rst_en", ram_en_o, 1'b0);
    tick();
    rst_n = 1'b1;

    // single port write then read
    set_port(0, 1, 0, 'h10, 32'hDEADBEEF, 1, 4'hF);
    @(negedge clk);
    chk("t1_wr_gnt", gnt_o, 2'b01);
    tick();
    set_port(0, 1, 0, 'h10, 32'h0, 0, 4'hF);
    @(negedge clk);
    chk("t1_rd_gnt", gnt_o, 2'b01);
    chk("t1_wr_rvalid", rvalid_o, 2'b01);
    tick();
    clear_all();
    @(negedge clk);
    chk("t1_rd_rvalid", rvalid_o, 2'b01);
    chk("t1_rdata", rdata_o, 32'hDEADBEEF);
    tick();

    // two ports contending: strict alternation
    do_reset();
    set_port(0, 1, 0, 'h40, $urandom, 1, 4'hF);
    set_port(1, 1, 0, 'h41, $urandom, 1, 4'hF);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t2_gnt", gnt_o, (i % 2) ? 2'b10 : 2'b01);
      if (i > 0) chk("t2_rvalid", rvalid_o, (i % 2) ? 2'b01 : 2'b10);
      tick();
    end
    clear_all();
    @(negedge clk);
    chk("t2_last_rvalid", rvalid_o, 2'b10);
    tick();

    // port 1 locked read-modify-write holds off port 0
    set_port(1, 1, 1, 'h10, 32'h0, 0, 4'hF);
    @(negedge clk);
    chk("t3_lock_gnt", gnt_o, 2'b10);
    tick();
    set_port(1, 0, 0, 'h10, 32'h0, 0, 4'hF);
    set_port(0, 1, 0, 'h20, 32'h0, 0, 4'hF);
    @(negedge clk);
    chk("t3_blocked", gnt_o, 2'b00);
    chk("t3_rd_rvalid", rvalid_o, 2'b10);
    chk("t3_rd_data", rdata_o, 32'hDEADBEEF);
    tick();
    set_port(1, 1, 0, 'h10, 32'hDEADBEF0, 1, 4'hF);
    @(negedge clk);
    chk("t3_unlock_gnt", gnt_o, 2'b10);
    tick();
    set_port(1, 0, 0, 'h10, 32'h0, 0, 4'h0);
    @(negedge clk);
    chk("t3_p0_gnt", gnt_o, 2'b01);
    tick();
    clear_all();
    tick();

    // abandoned lock broken by watchdog
    do_reset();
    set_port(0, 1, 1, 'h50, 32'h0, 0, 4'hF);
    @(negedge clk);
    chk("t4_lock_gnt", gnt_o, 2'b01);
    tick();
    set_port(0, 0, 0, 'h50, 32'h0, 0, 4'hF);
    set_port(1, 1, 0, 'h51, 32'h0, 0, 4'hF);
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk);
      chk("t4_idle_gnt", gnt_o, 2'b00);
      chk("t4_timeout", lock_timeout_o, i == TO);
      tick();
    end
    @(negedge clk);
    chk("t4_after_gnt", gnt_o, 2'b10);
    chk("t4_after_to", lock_timeout_o, 1'b0);
    tick();
    clear_all();
    tick();

    // byte-lane write merge
    set_port(0, 1, 0, 'h60, 32'h11223344, 1, 4'hF);
    tick();
    set_port(0, 1, 0, 'h60, 32'h0000AB00, 1, 4'b0010);
    tick();
    set_port(0, 1, 0, 'h60, 32'h0, 0, 4'hF);
    tick();
    clear_all();
    @(negedge clk);
    chk("t5_rvalid", rvalid_o, 2'b01);
    chk("t5_rdata", rdata_o, 32'h1122AB44);
    tick();

    // reset during a locked transfer with a read in flight
    do_reset();
    set_port(0, 1, 1, 'h10, 32'h0, 0, 4'hF);
    @(negedge clk);
    chk("t6_lock_gnt", gnt_o, 2'b01);
    tick();
    rst_n = 1'b0;
    clear_all();
    set_port(1, 1, 0, 'h20, 32'h0, 0, 4'hF);
    @(negedge clk);
    chk("t6_dropped", rvalid_o, 2'b00);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_p1_gnt", gnt_o, 2'b10);
    chk("t6_no_rvalid", rvalid_o, 2'b00);
    tick();
    clear_all();
    tick();

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < NP; p++) begin
        bit r;
        if (quiet[p] > 0) begin
          quiet[p]--;
          r = 0;
        end else begin
          r = ($urandom_range(0, 9) < 6);
          if ($urandom_range(0, 99) < 4) quiet[p] = $urandom_range(5, 24);
        end
        set_port(p, r, $urandom_range(0, 3) == 0, $urandom_range(0, 7),
                 $urandom, $urandom_range(0, 1) == 1, 4'($urandom));
      end
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst_n = 1'b1;
    clear_all();
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
